// File: rtl/param_code_lock_pkg.sv
// Shared types and default parameters for the serial code lock.
// Optional feature macro: PARAM_CODE_LOCK_AUTO_RELOCK_EN (see param_code_lock.sv).
package param_code_lock_pkg;

   typedef enum logic [1:0] {
      ST_ENTRY   = 2'd0,
      ST_ERROR   = 2'd1,
      ST_OPEN    = 2'd2,
      ST_LOCKOUT = 2'd3
   } state_t;

   localparam int unsigned     DEF_CODE_W      = 4;
   localparam logic [3:0]      DEF_CODE        = 4'b1011;
   localparam int unsigned     DEF_MAX_FAIL    = 3;
   localparam int unsigned     DEF_LOCKOUT_CYC = 1000;
   localparam int unsigned     DEF_UNLOCK_CYC  = 500;

   // $clog2 that never yields a zero-width vector
   function automatic int unsigned clog2_min1(input int unsigned val);
      int unsigned w;
      w = $clog2(val);
      return (w == 0) ? 1 : w;
   endfunction

endpackage

// File: rtl/param_code_lock_if.sv
// Keypad-side bus of the code lock: code bit strobe, submit strobe and status.
interface param_code_lock_if
   import param_code_lock_pkg::*;
#(
   parameter int unsigned FAIL_W = $clog2(DEF_MAX_FAIL + 1),
   parameter int unsigned IDX_W  = $clog2(DEF_CODE_W + 1)
);
   logic              data_in;
   logic              bit_valid;
   logic              submit;
   logic              locked;
   logic              unlocked;
   logic              lockout;
   logic [FAIL_W-1:0] fail_count;
   logic [IDX_W-1:0]  bit_idx;

   // Front end drives the strobes and observes status
   modport master (
      output data_in, bit_valid, submit,
      input  locked, unlocked, lockout, fail_count, bit_idx
   );

   // The lock consumes the strobes and reports status
   modport slave (
      input  data_in, bit_valid, submit,
      output locked, unlocked, lockout, fail_count, bit_idx
   );
endinterface

// File: rtl/param_code_lock_lock_timer.sv
// Loadable down-counter that saturates at zero; shared by lockout and relock timing.
module lock_timer #(
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic             i_en,
   output logic             o_zero_c
);
   logic [CNT_W-1:0] r_count;

   // Load has priority; counting stops at zero
   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_en && (r_count != '0)) begin
         r_count <= r_count - CNT_W'(1);
      end
   end

   assign o_zero_c = (r_count == '0);
endmodule

// File: rtl/param_code_lock.sv
// Parametrised serial code lock: MSB-first bit entry, failure counting, timed lockout.
// Optional feature macro: PARAM_CODE_LOCK_AUTO_RELOCK_EN (auto relock after UNLOCK_CYC).
module param_code_lock
   import param_code_lock_pkg::*;
#(
   parameter int unsigned       CODE_W      = DEF_CODE_W,
   parameter logic [CODE_W-1:0] CODE        = CODE_W'(DEF_CODE),
   parameter int unsigned       MAX_FAIL    = DEF_MAX_FAIL,
   parameter int unsigned       LOCKOUT_CYC = DEF_LOCKOUT_CYC,
   parameter int unsigned       UNLOCK_CYC  = DEF_UNLOCK_CYC
) (
   input  logic               clk,
   input  logic               reset,
   param_code_lock_if.slave   bus
);
   localparam int unsigned FAIL_W = $clog2(MAX_FAIL + 1);
   localparam int unsigned IDX_W  = $clog2(CODE_W + 1);
`ifdef PARAM_CODE_LOCK_AUTO_RELOCK_EN
   localparam int unsigned CNT_W  = clog2_min1((LOCKOUT_CYC > UNLOCK_CYC) ? LOCKOUT_CYC : UNLOCK_CYC);
`else
   localparam int unsigned CNT_W  = clog2_min1(LOCKOUT_CYC);
`endif
   localparam logic [FAIL_W-1:0] FAIL_LAST = FAIL_W'(MAX_FAIL - 1);
   localparam logic [FAIL_W-1:0] FAIL_MAX  = FAIL_W'(MAX_FAIL);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(CODE_W - 1);

   // Reject parameter sets the lock cannot implement
   if (CODE_W < 2)      begin : g_bad_code_w   $error("CODE_W must be at least 2");      end
   if (MAX_FAIL < 1)    begin : g_bad_max_fail $error("MAX_FAIL must be at least 1");    end
   if (LOCKOUT_CYC < 1) begin : g_bad_lockout  $error("LOCKOUT_CYC must be at least 1"); end
   if (UNLOCK_CYC < 1)  begin : g_bad_unlock   $error("UNLOCK_CYC must be at least 1");  end

   state_t            r_state;
   logic [FAIL_W-1:0] r_fail_count;
   logic [IDX_W-1:0]  r_bit_idx;
   logic              r_locked;
   logic              r_unlocked;
   logic              r_lockout;

   logic [CODE_W-1:0] w_code_shl;
   logic              w_exp_bit;
   logic              w_in_entry;
   logic              w_abandon;
   logic              w_strobe;
   logic              w_match;
   logic              w_mismatch;
   logic              w_final;
   logic              w_fail;
   logic              w_last_fail;
   logic              w_to_lockout;
   logic              w_tmr_load;
   logic [CNT_W-1:0]  w_tmr_val;
   logic              w_tmr_en;
   logic              w_tmr_zero;
   logic              w_relock_due;

   // Expected bit: shifting the code left by the progress puts it at the MSB
   assign w_code_shl   = CODE << r_bit_idx;
   assign w_exp_bit    = w_code_shl[CODE_W-1];

   // Entry-state events; submit masks a same-cycle bit strobe
   assign w_in_entry   = (r_state == ST_ENTRY);
   assign w_abandon    = w_in_entry && bus.submit && (r_bit_idx != '0);
   assign w_strobe     = w_in_entry && !bus.submit && bus.bit_valid;
   assign w_match      = w_strobe && (bus.data_in == w_exp_bit);
   assign w_mismatch   = w_strobe && (bus.data_in != w_exp_bit);
   assign w_final      = w_match && (r_bit_idx == IDX_LAST);
   assign w_fail       = w_abandon || w_mismatch;
   assign w_last_fail  = (r_fail_count == FAIL_LAST);
   assign w_to_lockout = w_fail && w_last_fail;

   // Timer control: load on entry to a timed state, count while in it
`ifdef PARAM_CODE_LOCK_AUTO_RELOCK_EN
   assign w_tmr_load   = w_to_lockout || w_final;
   assign w_tmr_val    = w_to_lockout ? CNT_W'(LOCKOUT_CYC - 1) : CNT_W'(UNLOCK_CYC - 1);
   assign w_tmr_en     = (r_state == ST_LOCKOUT) || (r_state == ST_OPEN);
   assign w_relock_due = w_tmr_zero;
`else
   assign w_tmr_load   = w_to_lockout;
   assign w_tmr_val    = CNT_W'(LOCKOUT_CYC - 1);
   assign w_tmr_en     = (r_state == ST_LOCKOUT);
   assign w_relock_due = 1'b0;
`endif

   lock_timer #(
      .CNT_W      (CNT_W)
   ) u_timer (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_tmr_load),
      .i_load_val (w_tmr_val),
      .i_en       (w_tmr_en),
      .o_zero_c   (w_tmr_zero)
   );

   // Lock FSM with registered Moore outputs updated alongside the state
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_ENTRY;
         r_bit_idx    <= '0;
         r_fail_count <= '0;
         r_locked     <= 1'b1;
         r_unlocked   <= 1'b0;
         r_lockout    <= 1'b0;
      end else begin
         case (r_state)
            ST_ENTRY: begin
               if (w_fail) begin
                  r_bit_idx <= '0;
                  if (w_last_fail) begin
                     r_state      <= ST_LOCKOUT;
                     r_fail_count <= FAIL_MAX;
                     r_lockout    <= 1'b1;
                  end else begin
                     r_fail_count <= r_fail_count + FAIL_W'(1);
                     if (w_mismatch) begin
                        r_state <= ST_ERROR;
                     end
                  end
               end else if (w_final) begin
                  r_state      <= ST_OPEN;
                  r_fail_count <= '0;
                  r_bit_idx    <= '0;
                  r_locked     <= 1'b0;
                  r_unlocked   <= 1'b1;
               end else if (w_match) begin
                  r_bit_idx <= r_bit_idx + IDX_W'(1);
               end
            end
            ST_ERROR: begin
               if (bus.submit) begin
                  r_state <= ST_ENTRY;
               end
            end
            ST_OPEN: begin
               if (bus.submit || w_relock_due) begin
                  r_state    <= ST_ENTRY;
                  r_locked   <= 1'b1;
                  r_unlocked <= 1'b0;
               end
            end
            ST_LOCKOUT: begin
               if (w_tmr_zero) begin
                  r_state      <= ST_ENTRY;
                  r_fail_count <= '0;
                  r_lockout    <= 1'b0;
               end
            end
            default: begin
               r_state    <= ST_ENTRY;
               r_bit_idx  <= '0;
               r_locked   <= 1'b1;
               r_unlocked <= 1'b0;
               r_lockout  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.locked     = r_locked;
   assign bus.unlocked   = r_unlocked;
   assign bus.lockout    = r_lockout;
   assign bus.fail_count = r_fail_count;
   assign bus.bit_idx    = r_bit_idx;
endmodule

// File: tb/tb_param_code_lock.sv
// Bench for param_code_lock: abstract per-cycle model plus directed literal checks.
module tb_param_code_lock;
   localparam int CODE_W   = 4;
   localparam int MAX_FAIL = 3;
   localparam int LOCK_CYC = 16;
   localparam int UNL_CYC  = 8;

   logic       clk;
   logic       reset;
   logic [3:0] code_v;
   int         n_checks;
   int         n_errors;

   // Model: mode 0=waiting for code, 1=error, 2=open, 3=lockout
   int         m_mode;
   int         m_prog;
   int         m_fails;
   int         m_left;
   bit         m_valid;

   param_code_lock_if #(.FAIL_W(2), .IDX_W(3)) bus ();

   param_code_lock #(
      .CODE_W      (4),
      .CODE        (4'b1011),
      .MAX_FAIL    (3),
      .LOCKOUT_CYC (16),
      .UNLOCK_CYC  (8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: progress is the length of the correct prefix entered so far
   always @(posedge clk) begin
      int  mode, prog, fails, left;
      bit  fail_ev, by_mismatch;
      mode = m_mode; prog = m_prog; fails = m_fails; left = m_left;
      fail_ev = 1'b0; by_mismatch = 1'b0;
      if (reset) begin
         mode = 0; prog = 0; fails = 0; left = 0;
      end else begin
         case (mode)
            0: begin
               if (bus.submit) begin
                  if (prog > 0) fail_ev = 1'b1;
                  prog = 0;
               end else if (bus.bit_valid) begin
                  if (bus.data_in == code_v[CODE_W-1-prog]) begin
                     prog = prog + 1;
                     if (prog == CODE_W) begin
                        mode = 2; fails = 0; prog = 0; left = UNL_CYC;
                     end
                  end else begin
                     fail_ev = 1'b1; by_mismatch = 1'b1; prog = 0;
                  end
               end
               if (fail_ev) begin
                  fails = fails + 1;
                  if (fails == MAX_FAIL) begin
                     mode = 3; left = LOCK_CYC;
                  end else if (by_mismatch) begin
                     mode = 1;
                  end
               end
            end
            1: if (bus.submit) mode = 0;
            2: begin
               if (bus.submit) mode = 0;
`ifdef PARAM_CODE_LOCK_AUTO_RELOCK_EN
               else begin
                  left = left - 1;
                  if (left == 0) mode = 0;
               end
`endif
            end
            default: begin
               left = left - 1;
               if (left == 0) begin
                  mode = 0; fails = 0;
               end
            end
         endcase
      end
      m_mode  <= mode;
      m_prog  <= prog;
      m_fails <= fails;
      m_left  <= left;
      if (reset) m_valid <= 1'b1;
   end

   // Per-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (m_valid) begin
         chk("cyc_locked",   int'(bus.locked),     (m_mode != 2) ? 1 : 0);
         chk("cyc_unlocked", int'(bus.unlocked),   (m_mode == 2) ? 1 : 0);
         chk("cyc_lockout",  int'(bus.lockout),    (m_mode == 3) ? 1 : 0);
         chk("cyc_fail_cnt", int'(bus.fail_count), m_fails);
         chk("cyc_bit_idx",  int'(bus.bit_idx),    m_prog);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic strobe(input logic b);
      bus.bit_valid = 1'b1;
      bus.data_in   = b;
      tick();
      bus.bit_valid = 1'b0;
      bus.data_in   = 1'b0;
   endtask

   task automatic press_submit();
      bus.submit = 1'b1;
      tick();
      bus.submit = 1'b0;
   endtask

   task automatic enter_code();
      strobe(1'b1); strobe(1'b0); strobe(1'b1); strobe(1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int  cnt;
      bit  seen_unl;
      code_v        = 4'b1011;
      n_checks      = 0;
      n_errors      = 0;
      m_valid       = 1'b0;
      m_mode        = 0; m_prog = 0; m_fails = 0; m_left = 0;
      reset         = 1'b1;
      bus.data_in   = 1'b0;
      bus.bit_valid = 1'b0;
      bus.submit    = 1'b0;
      tick(); tick();
      reset = 1'b0;
      chk("rst_locked",   int'(bus.locked),     1);
      chk("rst_unlocked", int'(bus.unlocked),   0);
      chk("rst_lockout",  int'(bus.lockout),    0);
      chk("rst_fail",     int'(bus.fail_count), 0);
      chk("rst_idx",      int'(bus.bit_idx),    0);

      // 1: correct code opens, submit relocks
      strobe(1'b1);
      chk("t1_idx1", int'(bus.bit_idx), 1);
      strobe(1'b0); strobe(1'b1); strobe(1'b1);
      chk("t1_unlocked", int'(bus.unlocked),   1);
      chk("t1_locked",   int'(bus.locked),     0);
      chk("t1_fail",     int'(bus.fail_count), 0);
      press_submit();
      chk("t1_relock",   int'(bus.locked),     1);

      // 2: mismatch on second bit goes to error; strobes ignored there
      strobe(1'b1); strobe(1'b1);
      chk("t2_fail",   int'(bus.fail_count), 1);
      chk("t2_locked", int'(bus.locked),     1);
      chk("t2_idx",    int'(bus.bit_idx),    0);
      enter_code();
      chk("t2_ign_unl",  int'(bus.unlocked),   0);
      chk("t2_ign_fail", int'(bus.fail_count), 1);
      press_submit();
      strobe(1'b1);
      chk("t2_back_entry", int'(bus.bit_idx), 1);

      // 3: three failed attempts lock out for exactly LOCK_CYC cycles
      do_reset();
      strobe(1'b0); press_submit();
      strobe(1'b0); press_submit();
      chk("t3_fail2", int'(bus.fail_count), 2);
      strobe(1'b0);
      chk("t3_lockout", int'(bus.lockout),    1);
      chk("t3_fail3",   int'(bus.fail_count), 3);
      cnt = 0;
      seen_unl = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (!bus.lockout) break;
         cnt++;
         if (i < 4) begin
            bus.bit_valid = 1'b1;
            bus.data_in   = code_v[3-i];
         end else begin
            bus.bit_valid = 1'b0;
         end
         tick();
         if (bus.unlocked) seen_unl = 1'b1;
      end
      bus.bit_valid = 1'b0;
      chk("t3_dwell",        cnt,                  16);
      chk("t3_no_unl",       int'(seen_unl),       0);
      chk("t3_fail_cleared", int'(bus.fail_count), 0);
      enter_code();
      chk("t3_unlock_after", int'(bus.unlocked), 1);
      press_submit();

      // 4: abandoned attempt and submit masking a bit strobe
      strobe(1'b1); strobe(1'b0);
      chk("t4_idx2", int'(bus.bit_idx), 2);
      press_submit();
      chk("t4_fail1",  int'(bus.fail_count), 1);
      chk("t4_idx0",   int'(bus.bit_idx),    0);
      chk("t4_entry",  int'(bus.locked),     1);
      strobe(1'b1);
      bus.submit = 1'b1; bus.bit_valid = 1'b1; bus.data_in = 1'b0;
      tick();
      bus.submit = 1'b0; bus.bit_valid = 1'b0;
      chk("t4_fail2",   int'(bus.fail_count), 2);
      chk("t4_no_lock", int'(bus.lockout),    0);
      bus.submit = 1'b1; bus.bit_valid = 1'b1; bus.data_in = 1'b1;
      tick();
      bus.submit = 1'b0; bus.bit_valid = 1'b0;
      chk("t4_dropped", int'(bus.bit_idx),    0);
      chk("t4_fail_hold", int'(bus.fail_count), 2);

      // 5: reset mid-entry and during lockout
      do_reset();
      strobe(1'b1); strobe(1'b0);
      chk("t5_idx2", int'(bus.bit_idx), 2);
      do_reset();
      chk("t5_idx_rst",  int'(bus.bit_idx),    0);
      chk("t5_lock_rst", int'(bus.locked),     1);
      strobe(1'b0); press_submit();
      strobe(1'b0); press_submit();
      strobe(1'b0);
      tick(); tick(); tick();
      chk("t5_in_lockout", int'(bus.lockout), 1);
      do_reset();
      chk("t5_lo_rst",   int'(bus.lockout),    0);
      chk("t5_fail_rst", int'(bus.fail_count), 0);
      chk("t5_lck_rst",  int'(bus.locked),     1);
      tick();
      chk("t5_stay_entry", int'(bus.lockout), 0);

      // 6: open hold time with and without auto relock
      enter_code();
      chk("t6_open", int'(bus.unlocked), 1);
`ifdef PARAM_CODE_LOCK_AUTO_RELOCK_EN
      cnt = 0;
      for (int i = 0; i < 120; i++) begin
         if (!bus.unlocked) break;
         cnt++;
         tick();
      end
      chk("t6_auto_relock_cyc", cnt, 8);
      chk("t6_relocked", int'(bus.locked), 1);
`else
      for (int i = 0; i < 100; i++) tick();
      chk("t6_still_open", int'(bus.unlocked), 1);
      press_submit();
      chk("t6_relocked", int'(bus.locked), 1);
`endif
      tick(); tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
